// File: rtl/traffic_phase_scheduler.sv
// Demand-actuated round-robin phase controller for a 4-approach intersection.
// Optional flashing mode is compiled in with the TRAFFIC_FLASH_EN macro.
module traffic_phase_scheduler #(
    parameter int TICK_DIV  = 4,
    parameter int CNT_W     = 8,
    parameter int MIN_GREEN = 4,
    parameter int MAX_GREEN = 12,
    parameter int YELLOW_T  = 2,
    parameter int ALLRED_T  = 1
) (
    input  logic       clk,
    input  logic       rst,
`ifdef TRAFFIC_FLASH_EN
    input  logic       flash,
`endif
    input  logic [3:0] req,
    output logic [7:0] signal,
    output logic [1:0] active,
    output logic [1:0] phase,
    output logic [3:0] pending
);

    typedef enum logic [2:0] {
        ST_STARTUP = 3'd0,
        ST_GREEN   = 3'd1,
        ST_YELLOW  = 3'd2,
        ST_ALLRED  = 3'd3
`ifdef TRAFFIC_FLASH_EN
        , ST_FLASH = 3'd4
`endif
    } state_t;

    localparam logic [1:0]       COL_Y   = 2'b01;
    localparam logic [1:0]       COL_G   = 2'b10;
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] MIN_G   = CNT_W'(MIN_GREEN);
    localparam logic [CNT_W-1:0] MAX_G   = CNT_W'(MAX_GREEN);
    localparam logic [CNT_W-1:0] YEL_T   = CNT_W'(YELLOW_T);
    localparam logic [CNT_W-1:0] AR_T    = CNT_W'(ALLRED_T);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] presc_q, presc_d;
    logic [CNT_W-1:0] e_q, e_d;
    logic [7:0]       signal_q, signal_d;
    logic [1:0]       active_q, active_d;
    logic [1:0]       phase_q, phase_d;
    logic [3:0]       pending_q, pending_d;
    logic             boot_q, boot_d;

    logic             tick;
    logic             enter;
    logic [CNT_W-1:0] e_inc;
    logic             others_pending;
    logic [1:0]       nxt;

    function automatic logic [7:0] lights(input logic [1:0] a, input logic [1:0] c);
        logic [7:0] v;
        int         hi;
        v = '0;
        hi = 7 - 2 * int'(a);
        v[hi -: 2] = c;
        return v;
    endfunction

    // First pending approach after cur, wrapping round to cur itself; else cur+1.
    function automatic logic [1:0] next_appr(input logic [1:0] cur, input logic [3:0] p);
        logic [1:0] idx;
        logic [1:0] r;
        r = cur + 2'd1;
        for (int k = 4; k >= 1; k--) begin
            idx = cur + 2'(k);
            if (p[idx]) r = idx;
        end
        return r;
    endfunction

    always_comb begin
        tick           = (presc_q == TICK_LAST);
        e_inc          = (e_q >= MAX_G) ? e_q : e_q + 1'b1;
        others_pending = |(pending_q & ~(4'b0001 << active_q));
        nxt            = boot_q ? 2'd0 : next_appr(active_q, pending_q);

        state_d   = state_q;
        presc_d   = tick ? '0 : presc_q + 1'b1;
        e_d       = tick ? e_inc : e_q;
        signal_d  = signal_q;
        active_d  = active_q;
        phase_d   = phase_q;
        boot_d    = boot_q;
        enter     = 1'b0;
        pending_d = pending_q | (req & ((state_q == ST_GREEN) ? ~(4'b0001 << active_q) : 4'b1111));

        case (state_q)
            ST_STARTUP: begin
                if (tick && e_inc >= YEL_T) begin
                    state_d  = ST_ALLRED;
                    signal_d = 8'h00;
                    active_d = 2'd3;
                    phase_d  = 2'd3;
                    boot_d   = 1'b1;
                    enter    = 1'b1;
                end
            end
            ST_GREEN: begin
                if (tick && others_pending &&
                    ((e_inc >= MIN_G && !req[active_q]) || e_inc >= MAX_G)) begin
                    state_d  = ST_YELLOW;
                    signal_d = lights(active_q, COL_Y);
                    phase_d  = 2'd2;
                    enter    = 1'b1;
                end
            end
            ST_YELLOW: begin
                if (tick && e_inc >= YEL_T) begin
                    state_d  = ST_ALLRED;
                    signal_d = 8'h00;
                    phase_d  = 2'd3;
                    boot_d   = 1'b0;
                    enter    = 1'b1;
                end
            end
            ST_ALLRED: begin
                if (tick && e_inc >= AR_T) begin
                    state_d        = ST_GREEN;
                    active_d       = nxt;
                    signal_d       = lights(nxt, COL_G);
                    phase_d        = 2'd1;
                    boot_d         = 1'b0;
                    enter          = 1'b1;
                    pending_d[nxt] = 1'b0;
                end
            end
`ifdef TRAFFIC_FLASH_EN
            ST_FLASH: begin
                pending_d = '0;
                if (!flash) begin
                    state_d  = ST_STARTUP;
                    signal_d = 8'h55;
                    active_d = 2'd0;
                    phase_d  = 2'd0;
                    boot_d   = 1'b0;
                    enter    = 1'b1;
                end else if (tick) begin
                    signal_d = (signal_q == 8'h55) ? 8'h00 : 8'h55;
                end
            end
`endif
            default: begin
                state_d   = ST_STARTUP;
                signal_d  = 8'h55;
                active_d  = 2'd0;
                phase_d   = 2'd0;
                pending_d = '0;
                boot_d    = 1'b0;
                enter     = 1'b1;
            end
        endcase

`ifdef TRAFFIC_FLASH_EN
        if (flash) begin
            pending_d = '0;
            if (state_q != ST_FLASH) begin
                state_d  = ST_FLASH;
                signal_d = 8'h55;
                active_d = 2'd0;
                phase_d  = 2'd0;
                boot_d   = 1'b0;
                enter    = 1'b1;
            end
        end
`endif

        if (enter) begin
            presc_d = '0;
            e_d     = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_STARTUP;
            presc_q   <= '0;
            e_q       <= '0;
            signal_q  <= 8'h55;
            active_q  <= 2'd0;
            phase_q   <= 2'd0;
            pending_q <= '0;
            boot_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            e_q       <= e_d;
            signal_q  <= signal_d;
            active_q  <= active_d;
            phase_q   <= phase_d;
            pending_q <= pending_d;
            boot_q    <= boot_d;
        end
    end

    assign signal  = signal_q;
    assign active  = active_q;
    assign phase   = phase_q;
    assign pending = pending_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Scoreboard bench for traffic_phase_scheduler: expected light/phase snapshots
// are queued per cycle index (edges since reset release) and compared on negedge.
module tb_traffic_phase_scheduler;

    logic       clk;
    logic       rst;
    logic       flash;
    logic [3:0] req;
    logic [7:0] signal;
    logic [1:0] active;
    logic [1:0] phase;
    logic [3:0] pending;

    traffic_phase_scheduler dut (
        .clk     (clk),
        .rst     (rst),
`ifdef TRAFFIC_FLASH_EN
        .flash   (flash),
`endif
        .req     (req),
        .signal  (signal),
        .active  (active),
        .phase   (phase),
        .pending (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [7:0] sig;
        logic [1:0] act;
        logic [1:0] ph;
        logic [3:0] pend;
    } exp_t;

    exp_t exp_q[$];
    int   cyc;
    int   n_tests;
    int   n_fail;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic push(input int c, input logic [7:0] s, input logic [1:0] a,
                        input logic [1:0] p, input logic [3:0] pd);
        exp_t e;
        e.cyc = c; e.sig = s; e.act = a; e.ph = p; e.pend = pd;
        exp_q.push_back(e);
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Monitor: safety every cycle, then retire due scoreboard entries.
    always @(negedge clk) begin
        if (!rst) begin
            int ng, ny;
            exp_t e;
            ng = 0; ny = 0;
            for (int i = 0; i < 4; i++) begin
                if (signal[2*i +: 2] == 2'b10) ng++;
                if (signal[2*i +: 2] == 2'b01) ny++;
            end
            chk("safety", {31'd0, (ng <= 1) && !(ng == 1 && ny > 0)}, 32'd1);
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                if (e.cyc < cyc) begin
                    chk("missed_slot", cyc, e.cyc);
                end else begin
                    chk("signal",  {24'd0, signal},  {24'd0, e.sig});
                    chk("active",  {30'd0, active},  {30'd0, e.act});
                    chk("phase",   {30'd0, phase},   {30'd0, e.ph});
                    chk("pending", {28'd0, pending}, {28'd0, e.pend});
                end
            end
        end
    end

    task automatic apply_reset(input logic [3:0] r);
        rst = 1'b1;
        req = r;
        flash = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        int budget;
        budget = 2000;
        while (cyc != n && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) chk("wait_timeout", cyc, n);
    endtask

    task automatic drain(input int budget);
        while (exp_q.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        chk("drain", exp_q.size(), 0);
        exp_q.delete();
        @(negedge clk);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        req = 4'd0;
        flash = 1'b0;

        // Idle startup and resting on approach 0
        apply_reset(4'b0000);
        push(0,   8'h55, 2'd0, 2'd0, 4'b0000);
        push(7,   8'h55, 2'd0, 2'd0, 4'b0000);
        push(8,   8'h00, 2'd3, 2'd3, 4'b0000);
        push(11,  8'h00, 2'd3, 2'd3, 4'b0000);
        push(12,  8'h80, 2'd0, 2'd1, 4'b0000);
        push(100, 8'h80, 2'd0, 2'd1, 4'b0000);
        push(212, 8'h80, 2'd0, 2'd1, 4'b0000);
        drain(400);

        // Gap-out to approach 2, then round-robin over 3, 0, 1
        apply_reset(4'b0100);
        push(0,   8'h55, 2'd0, 2'd0, 4'b0000);
        push(1,   8'h55, 2'd0, 2'd0, 4'b0100);
        push(12,  8'h80, 2'd0, 2'd1, 4'b0100);
        push(27,  8'h80, 2'd0, 2'd1, 4'b0100);
        push(28,  8'h40, 2'd0, 2'd2, 4'b0100);
        push(36,  8'h00, 2'd0, 2'd3, 4'b0100);
        push(40,  8'h08, 2'd2, 2'd1, 4'b0000);
        push(42,  8'h08, 2'd2, 2'd1, 4'b1011);
        push(56,  8'h04, 2'd2, 2'd2, 4'b1011);
        push(64,  8'h00, 2'd2, 2'd3, 4'b1011);
        push(68,  8'h02, 2'd3, 2'd1, 4'b0011);
        push(84,  8'h01, 2'd3, 2'd2, 4'b0011);
        push(92,  8'h00, 2'd3, 2'd3, 4'b0011);
        push(96,  8'h80, 2'd0, 2'd1, 4'b0010);
        push(112, 8'h40, 2'd0, 2'd2, 4'b0010);
        push(120, 8'h00, 2'd0, 2'd3, 4'b0010);
        push(124, 8'h20, 2'd1, 2'd1, 4'b0000);
        push(300, 8'h20, 2'd1, 2'd1, 4'b0000);
        wait_cyc(41);
        req = 4'b1011;
        @(negedge clk);
        req = 4'b0000;
        drain(400);

        // Max-out with approach 0 held and a one-cycle request on approach 1
        apply_reset(4'b0001);
        push(11,  8'h00, 2'd3, 2'd3, 4'b0001);
        push(12,  8'h80, 2'd0, 2'd1, 4'b0000);
        push(20,  8'h80, 2'd0, 2'd1, 4'b0000);
        push(21,  8'h80, 2'd0, 2'd1, 4'b0010);
        push(59,  8'h80, 2'd0, 2'd1, 4'b0010);
        push(60,  8'h40, 2'd0, 2'd2, 4'b0010);
        push(61,  8'h40, 2'd0, 2'd2, 4'b0011);
        push(68,  8'h00, 2'd0, 2'd3, 4'b0011);
        push(72,  8'h20, 2'd1, 2'd1, 4'b0001);
        wait_cyc(20);
        req = 4'b0011;
        @(negedge clk);
        req = 4'b0001;
        drain(200);

        // Asynchronous reset in the middle of yellow
        apply_reset(4'b0100);
        push(28,  8'h40, 2'd0, 2'd2, 4'b0100);
        wait_cyc(30);
        chk("pre_rst_phase", {30'd0, phase}, 32'd2);
        rst = 1'b1;
        #1;
        chk("rst_signal",  {24'd0, signal},  32'h55);
        chk("rst_pending", {28'd0, pending}, 32'd0);
        chk("rst_phase",   {30'd0, phase},   32'd0);
        chk("rst_active",  {30'd0, active},  32'd0);
        @(negedge clk);
        rst = 1'b0;
        push(0,   8'h55, 2'd0, 2'd0, 4'b0000);
        push(7,   8'h55, 2'd0, 2'd0, 4'b0100);
        push(8,   8'h00, 2'd3, 2'd3, 4'b0100);
        push(12,  8'h80, 2'd0, 2'd1, 4'b0100);
        drain(200);

`ifdef TRAFFIC_FLASH_EN
        // Flash mode entered during green, then released into startup
        apply_reset(4'b0000);
        push(20,  8'h80, 2'd0, 2'd1, 4'b0000);
        push(21,  8'h55, 2'd0, 2'd0, 4'b0000);
        push(24,  8'h55, 2'd0, 2'd0, 4'b0000);
        push(25,  8'h00, 2'd0, 2'd0, 4'b0000);
        push(29,  8'h55, 2'd0, 2'd0, 4'b0000);
        push(32,  8'h55, 2'd0, 2'd0, 4'b0000);
        push(39,  8'h55, 2'd0, 2'd0, 4'b0000);
        push(40,  8'h00, 2'd3, 2'd3, 4'b0000);
        push(44,  8'h80, 2'd0, 2'd1, 4'b0000);
        wait_cyc(20);
        flash = 1'b1;
        req = 4'b0110;
        wait_cyc(31);
        flash = 1'b0;
        req = 4'b0000;
        drain(200);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
